// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared definitions for the instruction-memory loader.
//                Holds the loader state encoding, the stream word size and
//                the default instruction-memory address width.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 14;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_byte_packer
//  Description : Assembles little-endian 32-bit words from a byte stream.
//                The first byte of a word lands in bits [7:0].
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - restart word assembly (drops partial bytes)
//                in_valid      - a byte is accepted this cycle
//                in_data[7:0]  - the accepted byte
//                word_valid    - high in the cycle the 4th byte is accepted
//                word[31:0]    - completed word, valid with word_valid
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  r_cnt;
  // Only the first three bytes need storage; the fourth completes the word
  // combinationally so the owner can act on it in the same cycle.
  logic [23:0] r_shift;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (in_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {in_data, r_shift[23:8]};
    end
  end

  assign word       = {in_data, r_shift};
  assign word_valid = in_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program image into instruction memory from a byte
//                stream: 4-byte little-endian word count N followed by N
//                little-endian instruction words. Holds the core in reset
//                while loading and reports done / err (sticky until start).
//  Parameters  : ADDR_W    - word-address width (capacity 2^ADDR_W words)
//                BASE_ADDR - first word address written
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                start                - one-cycle pulse beginning a load
//                rx_data, rx_valid    - incoming byte stream
//                rx_ready             - byte accepted when rx_valid && rx_ready
//                imem_we/addr/wdata   - instruction-memory write port
//                cpu_hold, busy       - load in progress
//                done, err            - sticky completion status
//  Options     : IMEM_LOADER_CHECKSUM_EN - expect a trailing 32-bit word equal
//                to the wrap-around sum of all loaded words
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Largest legal word count: the words from BASE_ADDR to the top of memory.
  localparam logic [63:0] LEN_CAP = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_remaining;
  logic                r_done;
  logic                r_err;
  logic                w_accept;
  logic                w_start_load;
  logic                w_word_valid;
  logic [31:0]         w_word;
  logic                w_len_too_big;

  assign w_accept      = rx_valid && rx_ready;
  assign w_start_load  = (r_state == S_IDLE) && start;
  assign w_len_too_big = {32'd0, w_word} > LEN_CAP;

  imem_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_start_load),
    .in_valid   (w_accept),
    .in_data    (rx_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  // Sum the word being written, so the total is complete when CSUM starts.
  always_ff @(posedge clk) begin
    if (rst || w_start_load) begin
      r_sum <= 32'd0;
    end else if (r_state == S_WRITE) begin
      r_sum <= r_sum + r_wdata;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rx_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        rx_ready = 1'b1;
        if (w_word_valid) begin
          if (w_len_too_big) begin
            w_state_nxt = S_ERR;
          end else if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (w_word_valid) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // r_remaining still counts the word being written here.
        if (r_remaining != 32'd1) begin
          w_state_nxt = S_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        rx_ready = 1'b1;
        if (w_word_valid) begin
          w_state_nxt = (w_word == r_sum) ? S_DONE : S_ERR;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_wdata     <= 32'd0;
      r_remaining <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= ADDR_W'(BASE_ADDR);
          end
        end
        S_LEN: begin
          if (w_word_valid) begin
            r_remaining <= w_word;
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_wdata <= w_word;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - 32'd1;
        end
        default: ;
      endcase
      // Status flags rise together with the DONE / ERR state and then stick.
      if (w_state_nxt == S_DONE) begin
        r_done <= 1'b1;
      end
      if (w_state_nxt == S_ERR) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_we    = (r_state == S_WRITE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign cpu_hold   = busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader (ADDR_W=4, BASE_ADDR=0).
//                Table-driven loads, hand-written corner sequences and
//                randomized loads checked against a stream-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW   = 4;
  localparam int CAP  = 16;
  localparam int BASE = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          pulse_idx;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_rise_q[$];
  int          err_rise_q[$];
  int          busy_fall_q[$];
  logic        done_q = 1'b0;
  logic        err_q  = 1'b0;
  logic        busy_q = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1 && done_q !== 1'b1) done_rise_q.push_back(cyc);
    if (err === 1'b1 && err_q !== 1'b1) err_rise_q.push_back(cyc);
    if (busy === 1'b0 && busy_q === 1'b1) busy_fall_q.push_back(cyc);
    done_q <= done;
    err_q  <= err;
    busy_q <= busy;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  bq_t         stream;
  logic [31:0] words[$];
  logic [31:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  int          acc_cyc_q[$];
  int          wr_base, done_base, err_base, busy_base;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, ".imem_we"}, 64'(imem_we), 64'd0);
    check({tag, ".imem_addr"}, 64'(imem_addr), 64'(BASE));
    check({tag, ".imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".err"}, 64'(err), 64'd0);
  endtask

  // Present one byte until it is taken, then idle for 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int t;
    t        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    if (pulse) start = 1'b1;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      t++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept_timeout: rx_ready %b required 1", rx_ready);
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
      acc_cyc_q.push_back(cyc);
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic build_stream(input logic [31:0] n, input bit bad_csum);
    logic [31:0] sum;
    logic [31:0] w;
    sum = 32'd0;
    stream.delete();
    for (int k = 0; k < 4; k++) stream.push_back(n[8*k +: 8]);
    if (n <= 32'(CAP - BASE)) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
        sum = sum + w;
      end
      if (CSUM) begin
        w = sum + (bad_csum ? 32'd1 : 32'd0);
        for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
      end
    end
  endtask

  // Stream-level reference: decode count and words, decide the outcome.
  task automatic model_from_stream();
    logic [31:0] n, sum, c, w;
    int p;
    exp_q.delete();
    n = {stream[3], stream[2], stream[1], stream[0]};
    if (n > 32'(CAP - BASE)) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    p   = 4;
    sum = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      w = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
      exp_q.push_back(w);
      sum = sum + w;
      p   = p + 4;
    end
    if (CSUM) begin
      c        = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
      exp_done = (c == sum);
      exp_err  = (c != sum);
    end else begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end
  endtask

  task automatic run_load(input int gap, input int pulse_idx);
    int t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start.busy", 64'(busy), 64'd1);
    check("start.cpu_hold", 64'(cpu_hold), 64'd1);
    check("start.done_clr", 64'(done), 64'd0);
    check("start.err_clr", 64'(err), 64'd0);
    wr_base   = wr_data_q.size();
    done_base = done_rise_q.size();
    err_base  = err_rise_q.size();
    busy_base = busy_fall_q.size();
    acc_cyc_q.delete();
    foreach (stream[i]) send_byte(stream[i], (gap < 0) ? int'($urandom_range(3)) : gap, i == pulse_idx);
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_end_timeout: busy %b required 0", busy);
    end
    @(negedge clk); #1;
  endtask

  task automatic check_load(input string tag);
    int nw, nd, ne, nb, last;
    nw = wr_data_q.size() - wr_base;
    check({tag, ".n_writes"}, 64'(nw), 64'(exp_q.size()));
    for (int i = 0; i < nw && i < exp_q.size(); i++) begin
      check({tag, ".addr"}, 64'(wr_addr_q[wr_base+i]), 64'((BASE + i) % CAP));
      check({tag, ".data"}, 64'(wr_data_q[wr_base+i]), 64'(exp_q[i]));
      if (4*i + 7 < acc_cyc_q.size())
        check({tag, ".wr_latency"}, 64'(wr_cyc_q[wr_base+i]), 64'(acc_cyc_q[4*i+7]));
    end
    check({tag, ".done"}, 64'(done), 64'(exp_done));
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    check({tag, ".rx_ready_after"}, 64'(rx_ready), 64'd0);
    nd = done_rise_q.size() - done_base;
    ne = err_rise_q.size() - err_base;
    nb = busy_fall_q.size() - busy_base;
    check({tag, ".done_rises"}, 64'(nd), 64'(exp_done));
    check({tag, ".err_rises"}, 64'(ne), 64'(exp_err));
    check({tag, ".busy_falls"}, 64'(nb), 64'd1);
    // Status follows the final write by one cycle, or the decisive byte.
    if (!CSUM && nw > 0) last = wr_cyc_q[wr_base+nw-1] + 1;
    else                 last = acc_cyc_q[acc_cyc_q.size()-1];
    if (nd > 0) check({tag, ".done_cycle"}, 64'(done_rise_q[done_base]), 64'(last));
    if (ne > 0) check({tag, ".err_cycle"}, 64'(err_rise_q[err_base]), 64'(last));
    if (nb > 0) check({tag, ".busy_fall_cycle"}, 64'(busy_fall_q[busy_base]), 64'(last + 1));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Bytes offered while idle are not taken.
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle.rx_ready", 64'(rx_ready), 64'd0);
      check("idle.busy", 64'(busy), 64'd0);
    end
    rx_valid = 1'b0;

    vecs[0] = '{32'd2, 32'h00100513, 32'h00200593, 0, -1, 1'b1, 1'b0, 2};
    vecs[1] = '{32'd0, 32'h0, 32'h0, 0, -1, 1'b1, 1'b0, 0};
    vecs[2] = '{32'd17, 32'h0, 32'h0, 0, -1, 1'b0, 1'b1, 0};
    vecs[3] = '{32'd2, 32'h00100513, 32'h00200593, 6, 5, 1'b1, 1'b0, 2};
    vecs[4] = '{32'd16, 32'hDEADBEEF, 32'h12345678, 0, -1, 1'b1, 1'b0, 16};
    vecs[5] = '{32'hFFFFFFFF, 32'h0, 32'h0, 1, -1, 1'b0, 1'b1, 0};
    vecs[6] = '{32'd1, 32'h00000013, 32'h0, 2, 2, 1'b1, 1'b0, 1};

    foreach (vecs[v]) begin
      words.delete();
      for (int i = 0; i < 17; i++)
        words.push_back((i == 0) ? vecs[v].w0 : (i == 1) ? vecs[v].w1 : vecs[v].w0 + 32'(i) * 32'h01010101);
      build_stream(vecs[v].n, 1'b0);
      run_load(vecs[v].gap, vecs[v].pulse_idx);
      exp_q.delete();
      for (int i = 0; i < vecs[v].exp_writes; i++) exp_q.push_back(words[i]);
      exp_done = vecs[v].exp_done;
      exp_err  = vecs[v].exp_err;
      check_load($sformatf("vec%0d", v));
      if (vecs[v].gap == 0 && wr_data_q.size() - wr_base >= 2)
        check($sformatf("vec%0d.throughput", v), 64'(wr_cyc_q[wr_base+1] - wr_cyc_q[wr_base]), 64'd5);
    end

    // done stays high while idle.
    repeat (3) @(posedge clk);
    #1;
    check("sticky.done", 64'(done), 64'd1);
    check("sticky.busy", 64'(busy), 64'd0);

    // Reset in the middle of a load, then a clean load.
    words.delete();
    words.push_back(32'h00100513);
    words.push_back(32'h00200593);
    build_stream(32'd2, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    run_load(0, -1);
    model_from_stream();
    check_load("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_load(0, -1);
    exp_q.delete();
    exp_q.push_back(32'h00000013);
    exp_done = 1'b1;
    exp_err  = 1'b0;
    check_load("csum_good");
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00};
    run_load(0, -1);
    exp_done = 1'b0;
    exp_err  = 1'b1;
    check_load("csum_bad");
`endif

    for (int r = 0; r < 25; r++) begin
      logic [31:0] n;
      words.delete();
      for (int i = 0; i < 16; i++) words.push_back($urandom);
      n = ($urandom_range(4) == 0) ? 32'($urandom_range(300, 17)) : 32'($urandom_range(16));
      build_stream(n, $urandom_range(3) == 0);
      run_load(-1, ($urandom_range(3) == 0) ? int'($urandom_range(stream.size() - 1)) : -1);
      model_from_stream();
      check_load($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
